// File: rtl/ysyx_22050612_ctrl_pkg.sv
// Shared definitions for the multi-cycle core controller.
// State encoding doubles as the debug state output.
package ysyx_22050612_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_FWAIT = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_MWAIT = 3'd5,
    S_WB    = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

endpackage

// File: rtl/ysyx_22050612_ctrl_timer.sv
// Memory-response wait counter.
// expired fires on the cycle that completes the TIMEOUT-th wait.
module ysyx_22050612_WaitTimer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = enable && (cnt == TIMEOUT - 8'd1);

endmodule

// File: rtl/ysyx_22050612_ctrl.sv
// Multi-cycle controller: fetch, execute, memory, write-back.
// Bus responses are only honoured in the state waiting for them.
module ysyx_22050612_ctrl
  import ysyx_22050612_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEF_RESET_PC,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_req,
  output logic [63:0] if_addr,
  input  logic        if_ready,
  input  logic        if_rvalid,
  input  logic [31:0] if_rdata,
  output logic [31:0] inst,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_ebreak,
  input  logic [63:0] dnpc,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  output logic        gpr_wen,
  output logic [63:0] pc,
  output logic        halt,
  output logic        err,
  output logic [63:0] instret,
  output logic [2:0]  state
);

  state_t st_q, st_d;
  logic   inst_ld;
  logic   waiting;
  logic   progress;
  logic   stall;
  logic   expired;

  assign waiting = (st_q == S_FETCH) || (st_q == S_FWAIT)
                || (st_q == S_MEM)   || (st_q == S_MWAIT);

  assign progress = ((st_q == S_FETCH) && if_ready)
                 || ((st_q == S_FWAIT) && if_rvalid)
                 || ((st_q == S_MEM)   && mem_ready)
                 || ((st_q == S_MWAIT) && mem_rvalid);

  assign stall = waiting && !progress;

  // Any cycle that is not a stall restarts the count for the next wait.
  ysyx_22050612_WaitTimer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!stall),
    .enable  (stall),
    .expired (expired)
  );

  always_comb begin
    st_d    = st_q;
    if_req  = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    gpr_wen = 1'b0;
    inst_ld = 1'b0;
    unique case (st_q)
      S_IDLE: st_d = S_FETCH;
      S_FETCH: begin
        if_req = 1'b1;
        if (if_ready) begin
          inst_ld = if_rvalid;
          st_d    = if_rvalid ? S_EXEC : S_FWAIT;
        end
      end
      S_FWAIT: begin
        if (if_rvalid) begin
          inst_ld = 1'b1;
          st_d    = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (1'b1)
          dec_ebreak:           st_d = S_HALT;
          dec_load | dec_store: st_d = S_MEM;
          default:              st_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = dec_store;
        if (mem_ready) begin
          st_d = mem_rvalid ? S_WB : S_MWAIT;
        end
      end
      S_MWAIT: begin
        if (mem_rvalid) begin
          st_d = S_WB;
        end
      end
      S_WB: begin
        gpr_wen = !dec_store;
        st_d    = S_FETCH;
      end
      S_HALT: st_d = S_HALT;
      default: st_d = S_IDLE;
    endcase
    if (expired) begin
      st_d = S_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      pc      <= RESET_PC;
      inst    <= NOP_INST;
      instret <= '0;
      err     <= 1'b0;
    end else begin
      st_q <= st_d;
      if (inst_ld) begin
        inst <= if_rdata;
      end
      if (st_q == S_WB) begin
        pc      <= dnpc;
        instret <= instret + 64'd1;
      end
      if (expired) begin
        err <= 1'b1;
      end
    end
  end

  assign if_addr = pc;
  assign halt    = (st_q == S_HALT);
  assign state   = st_q;

endmodule

// File: doc/ysyx_22050612_ctrl.md
YSYX_22050612_CTRL -- requirements
Module: ysyx_22050612_CTRL

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000: pc value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 8'd255: maximum wait cycles for any memory response.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port if_req, output, 1: instruction fetch request.
REQ-006 SHALL have port if_addr, output, 64: fetch address, equal to pc.
REQ-007 SHALL have port if_ready, input, 1: fetch request accepted.
REQ-008 SHALL have port if_rvalid, input, 1: fetch data valid.
REQ-009 SHALL have port if_rdata, input, 32: fetched instruction.
REQ-010 SHALL have port inst, output, 32: latched instruction driving decode/EXU.
REQ-011 SHALL have port dec_load, input, 1: decoded instruction is a load.
REQ-012 SHALL have port dec_store, input, 1: decoded instruction is a store.
REQ-013 SHALL have port dec_ebreak, input, 1: decoded instruction is ebreak.
REQ-014 SHALL have port dnpc, input, 64: next pc from EXU.
REQ-015 SHALL have port mem_req, output, 1: data memory request.
REQ-016 SHALL have port mem_we, output, 1: 1 = store, 0 = load; valid while mem_req=1.
REQ-017 SHALL have ports mem_ready, input, 1 (request accepted) and mem_rvalid, input, 1 (load data or store acknowledge).
REQ-018 SHALL have port gpr_wen, output, 1: register-file write-enable gate.
REQ-019 SHALL have port pc, output, 64: architectural pc.
REQ-020 SHALL have ports halt, output, 1; err, output, 1; instret, output, 64 (retired-instruction count); state, output, 3 (debug).

Function
REQ-021 SHALL implement states IDLE, FETCH, FWAIT, EXEC, MEM, MWAIT, WB, HALT.
REQ-022 IDLE SHALL last exactly one cycle after reset, then go to FETCH.
REQ-023 FETCH SHALL hold if_req=1 until if_ready=1; with if_rvalid=0 in that cycle go to FWAIT; with if_ready=if_rvalid=1 in the same cycle, latch inst and go directly to EXEC.
REQ-024 FWAIT SHALL hold if_req=0 and, on if_rvalid=1, latch if_rdata into inst and go to EXEC.
REQ-025 EXEC SHALL last one cycle; priority: dec_ebreak -> HALT; dec_load or dec_store -> MEM; otherwise -> WB.
REQ-026 MEM SHALL hold mem_req=1, with mem_we=dec_store, until mem_ready=1; same-cycle mem_rvalid=1 goes directly to WB, otherwise to MWAIT.
REQ-027 MWAIT SHALL hold mem_req=0 and go to WB on mem_rvalid=1.
REQ-028 WB SHALL last one cycle: gpr_wen=1 unless the instruction is a store; pc<=dnpc; instret<=instret+1 (64-bit wrap); next state FETCH.
REQ-029 gpr_wen SHALL be 0 in every state other than WB.
REQ-030 if_rvalid and mem_rvalid SHALL be ignored outside FETCH/FWAIT and MEM/MWAIT respectively.
REQ-031 A wait counter SHALL clear on entry to FETCH/FWAIT/MEM/MWAIT and increment each cycle waiting; on reaching TIMEOUT it SHALL force HALT with err=1.
REQ-032 HALT SHALL be terminal until rst: halt=1, all requests 0, pc and instret frozen.
REQ-033 Minimum latency, zero-wait memory: 3 cycles per ALU instruction, 4 per load/store.
REQ-034 state SHALL encode IDLE..HALT as 0..7 in the order of REQ-021.

Reset
REQ-035 On rst=1 at posedge: state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), instret=0, wait counter=0, halt=0, err=0.
REQ-036 All request outputs and gpr_wen SHALL be 0 in the cycle after rst, including when rst asserts mid-transaction; late responses SHALL be ignored.

Structure
REQ-037 State encodings, RESET_PC and the nop constant SHALL live in shared package ysyx_22050612_ctrl_pkg.
REQ-038 The wait counter SHALL be sub-module ysyx_22050612_WaitTimer (clear, enable, expired).

Verification
REQ-039 ALU instruction with zero-wait memory, dnpc=pc+4: pc goes 0x80000000 -> 0x80000004; gpr_wen=1 for exactly one cycle; instret=1 after 3 cycles.
REQ-040 Load with if_rvalid delayed 2 cycles and mem_rvalid delayed 3 cycles: gpr_wen pulses once in WB; mem_we=0 throughout MEM.
REQ-041 Store: mem_we=1 while mem_req=1; gpr_wen stays 0 for the whole instruction; instret increments by 1.
REQ-042 ebreak fetched: HALT is entered after EXEC; halt=1, err=0; pc remains unchanged for 10 further cycles.
REQ-043 if_rvalid never asserted: err=1 and halt=1 exactly TIMEOUT (255) wait cycles after FWAIT entry.
REQ-044 rst asserted during MWAIT with mem_rvalid arriving 1 cycle later: state=IDLE, pc=0x80000000, gpr_wen stays 0.
